// File: rtl/tone_decoder_if.sv
// Tone decoder bus: tone pin toward the decoder, recovered note description back out.
// The decoder takes the master side; the consumer (sequence matcher or bench) takes slave.
interface tone_decoder_if #(
   parameter int HP_W  = 16,
   parameter int CNT_W = 16
);
   logic             tone_in;
   logic             note_valid;
   logic [HP_W-1:0]  note_halfperiod;
   logic [CNT_W-1:0] note_cycles;
   logic             tone_active;

   modport master (
      input  tone_in,
      output note_valid,
      output note_halfperiod,
      output note_cycles,
      output tone_active
   );

   modport slave (
      output tone_in,
      input  note_valid,
      input  note_halfperiod,
      input  note_cycles,
      input  tone_active
   );
endinterface

// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures high time per cycle, groups matching cycles into notes.
// Optional TONE_DECODER_GLITCH_FILTER_EN adds a 3-tap majority filter ahead of edge detection.
module tone_decoder #(
   parameter int HP_W       = 16,
   parameter int CNT_W      = 16,
   parameter int TOL        = 4,
   parameter int MIN_CYCLES = 2
) (
   input  logic           hwclk,
   input  logic           rst_n,
   tone_decoder_if.master bus
);
   localparam int LW = HP_W + 2;

   localparam logic [HP_W-1:0]  HP_ZERO  = {HP_W{1'b0}};
   localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);
   localparam logic [HP_W-1:0]  HP_MAX   = {HP_W{1'b1}};
   localparam logic [HP_W:0]    TOL_HP   = (HP_W+1)'(TOL);
   localparam logic [LW-1:0]    L_ZERO   = {LW{1'b0}};
   localparam logic [LW-1:0]    L_ONE    = LW'(1);
   localparam logic [LW-1:0]    L_MAX    = {LW{1'b1}};
   localparam logic [LW-1:0]    TOL_L    = LW'(TOL);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Magnitude of a - b, evaluated one bit wider so the sign is never lost.
   function automatic logic [HP_W:0] abs_diff(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
      logic [HP_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[HP_W]) begin
         return ~d + (HP_W+1)'(1);
      end else begin
         return d;
      end
   endfunction

   logic s1_q, s2_q, s3_q;
   logic lvl_s, lvl_prev_s, rise_s, fall_s;

`ifdef TONE_DECODER_GLITCH_FILTER_EN
   logic s4_q, f1_q, f2_q;
   assign lvl_s      = f1_q;
   assign lvl_prev_s = f2_q;
`else
   assign lvl_s      = s2_q;
   assign lvl_prev_s = s3_q;
`endif

   assign rise_s = lvl_s & ~lvl_prev_s;
   assign fall_s = ~lvl_s & lvl_prev_s;

   state_t           state_q, state_d;
   logic [HP_W-1:0]  hcnt_q, hcnt_d;
   logic [LW-1:0]    lcnt_q, lcnt_d;
   logic [HP_W-1:0]  ref_q, ref_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             nv_q, nv_d;
   logic [HP_W-1:0]  nhp_q, nhp_d;
   logic [CNT_W-1:0] ncyc_q, ncyc_d;
   logic             act_q, act_d;
   logic             end_note_s;
   logic [LW-1:0]    silence_lim_s;

   assign silence_lim_s = {1'b0, ref_q, 1'b0} + TOL_L;

   // Next-state, measurement and note-emit logic.
   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      lcnt_d     = lcnt_q;
      ref_d      = ref_q;
      cyc_d      = cyc_q;
      end_note_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_s) begin
               state_d = ST_HIGH;
               hcnt_d  = HP_ONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (fall_s) begin
               if (cyc_q == CNT_ZERO) begin
                  ref_d = hcnt_q;
                  cyc_d = CNT_ONE;
               end else if (abs_diff(hcnt_q, ref_q) <= TOL_HP) begin
                  cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
               end else begin
                  end_note_s = 1'b1;
                  ref_d      = hcnt_q;
                  cyc_d      = CNT_ONE;
               end
               state_d = ST_LOW;
               lcnt_d  = L_ONE;
            end else if (hcnt_q == HP_MAX) begin
               // Stuck-high line: give up on this cycle rather than wait for a fall.
               end_note_s = 1'b1;
               cyc_d      = CNT_ZERO;
               state_d    = ST_IDLE;
            end else begin
               hcnt_d = hcnt_q + HP_ONE;
            end
         end
         ST_LOW: begin
            if (rise_s) begin
               state_d = ST_HIGH;
               hcnt_d  = HP_ONE;
            end else if (lcnt_q >= silence_lim_s) begin
               end_note_s = 1'b1;
               cyc_d      = CNT_ZERO;
               state_d    = ST_IDLE;
            end else begin
               lcnt_d = (lcnt_q == L_MAX) ? lcnt_q : lcnt_q + L_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hcnt_d  = HP_ZERO;
            lcnt_d  = L_ZERO;
            ref_d   = HP_ZERO;
            cyc_d   = CNT_ZERO;
         end
      endcase

      // The ending note is always the one held in ref_q/cyc_q before this cycle's update.
      nv_d = end_note_s && (cyc_q >= CNT_MIN);
      if (nv_d) begin
         nhp_d  = ref_q;
         ncyc_d = cyc_q;
      end else begin
         nhp_d  = nhp_q;
         ncyc_d = ncyc_q;
      end
      act_d = (cyc_q != CNT_ZERO);
   end

   // Synchronizer, optional filter, FSM and registered outputs.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
         s4_q    <= 1'b0;
         f1_q    <= 1'b0;
         f2_q    <= 1'b0;
`endif
         state_q <= ST_IDLE;
         hcnt_q  <= HP_ZERO;
         lcnt_q  <= L_ZERO;
         ref_q   <= HP_ZERO;
         cyc_q   <= CNT_ZERO;
         nv_q    <= 1'b0;
         nhp_q   <= HP_ZERO;
         ncyc_q  <= CNT_ZERO;
         act_q   <= 1'b0;
      end else begin
         s1_q    <= bus.tone_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
         s4_q    <= s3_q;
         f1_q    <= maj3(s2_q, s3_q, s4_q);
         f2_q    <= f1_q;
`endif
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         lcnt_q  <= lcnt_d;
         ref_q   <= ref_d;
         cyc_q   <= cyc_d;
         nv_q    <= nv_d;
         nhp_q   <= nhp_d;
         ncyc_q  <= ncyc_d;
         act_q   <= act_d;
      end
   end

   assign bus.note_valid      = nv_q;
   assign bus.note_halfperiod = nhp_q;
   assign bus.note_cycles     = ncyc_q;
   assign bus.tone_active     = act_q;
endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed and random tones checked against a note-level model.
module tb_tone_decoder;
   localparam int TOL = 4;
   localparam int MIN_CYCLES = 2;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      int hp;
      int cyc;
      int at;
   } note_t;

   logic hwclk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc_cnt = 0;
   int   vectors = 0;
   int   miscompares = 0;
   note_t got_q[$];
   note_t exp_q[$];
   int   m_ref = 0;
   int   m_cnt = 0;
   logic prev_nv = 1'b0;

   tone_decoder_if #(.HP_W(16), .CNT_W(16)) bus_if ();

   tone_decoder #(.HP_W(16), .CNT_W(16), .TOL(TOL), .MIN_CYCLES(MIN_CYCLES)) dut (
      .hwclk (hwclk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 hwclk = ~hwclk;

   always @(posedge hwclk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse collector; also guards against back-to-back note_valid.
   always @(negedge hwclk) begin
      if (bus_if.note_valid === 1'b1) begin
         note_t n;
         n.hp  = int'(bus_if.note_halfperiod);
         n.cyc = int'(bus_if.note_cycles);
         n.at  = cyc_cnt;
         got_q.push_back(n);
         check("nv_back_to_back", {63'd0, prev_nv}, 64'd0);
      end
      prev_nv = (bus_if.note_valid === 1'b1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge hwclk);
         #1;
      end
   endtask

   task automatic m_finish(input int at);
      if (m_cnt >= MIN_CYCLES) begin
         note_t n;
         n.hp  = m_ref;
         n.cyc = m_cnt;
         n.at  = at;
         exp_q.push_back(n);
      end
      m_cnt = 0;
   endtask

   task automatic m_high(input int h, input int fall);
      int d;
      d = (h > m_ref) ? h - m_ref : m_ref - h;
      if (m_cnt == 0) begin
         m_ref = h;
         m_cnt = 1;
      end else if (d <= TOL) begin
         m_cnt++;
      end else begin
         m_finish(fall + LAT);
         m_ref = h;
         m_cnt = 1;
      end
   endtask

   task automatic m_low(input int l, input int fall);
      if (m_cnt != 0 && l > 2 * m_ref + TOL) m_finish(fall + LAT + 2 * m_ref + TOL);
   endtask

   task automatic play(input int h, input int l);
      int fall;
      bus_if.tone_in = 1'b1;
      step(h);
      bus_if.tone_in = 1'b0;
      fall = cyc_cnt;
      m_high(h, fall);
      m_low(l, fall);
      step(l);
   endtask

   task automatic play_glitch();
      int f1, f2;
      bus_if.tone_in = 1'b1;
      step(100);
      bus_if.tone_in = 1'b0;
      f1 = cyc_cnt;
      step(40);
      bus_if.tone_in = 1'b1;
      step(1);
      bus_if.tone_in = 1'b0;
      f2 = cyc_cnt;
      step(59);
`ifdef TONE_DECODER_GLITCH_FILTER_EN
      m_high(100, f1);
      m_low(100, f1);
`else
      m_high(100, f1);
      m_low(40, f1);
      m_high(1, f2);
      m_low(59, f2);
`endif
   endtask

   task automatic compare_notes(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check({tag, "_hp"}, 64'(got_q[i].hp), 64'(exp_q[i].hp));
         check({tag, "_cyc"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
         if (exp_q[i].at >= 0) check({tag, "_time"}, 64'(got_q[i].at), 64'(exp_q[i].at));
      end
      if (exp_q.size() > 0) begin
         check({tag, "_hold_hp"}, 64'(bus_if.note_halfperiod), 64'(exp_q[exp_q.size()-1].hp));
         check({tag, "_hold_cyc"}, 64'(bus_if.note_cycles), 64'(exp_q[exp_q.size()-1].cyc));
      end
      check({tag, "_active"}, {63'd0, bus_if.tone_active}, {63'd0, (m_cnt != 0)});
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int base, k, h, l, r;
      bus_if.tone_in = 1'b0;
      #2 rst_n = 1'b0;
      step(3);
      check("rst_valid", {63'd0, bus_if.note_valid}, 64'd0);
      check("rst_hp", 64'(bus_if.note_halfperiod), 64'd0);
      check("rst_cyc", 64'(bus_if.note_cycles), 64'd0);
      check("rst_active", {63'd0, bus_if.tone_active}, 64'd0);
      rst_n = 1'b1;
      step(1000);
      compare_notes("idle");

      // Steady 100/100 tone then silence.
      for (int i = 0; i < 9; i++) play(100, 100);
      play(100, 300);
      compare_notes("steady");

      // Frequency change splits notes.
      for (int i = 0; i < 5; i++) play(200, 200);
      for (int i = 0; i < 5; i++) play(150, 150);
      play(150, 400);
      compare_notes("freq_change");

      // Jitter within tolerance, then a 105 split.
      play(100, 100); play(103, 100); play(97, 100);
      play(104, 100); play(96, 100); play(100, 100);
      play(105, 100); play(105, 300);
      compare_notes("tolerance");

      // Silence boundary: low == 2*ref+TOL keeps the note, one more clock ends it.
      play(100, 204); play(100, 205);
      play(100, 300);
      compare_notes("silence_edge");

      // Single cycle is too short to report.
      play(50, 300);
      compare_notes("short_note");

      // Stuck-high line saturates the high counter and ends the note.
      for (int i = 0; i < 3; i++) play(100, 100);
      bus_if.tone_in = 1'b1;
      step(65560);
      m_finish(-1);
      check("stuck_active", {63'd0, bus_if.tone_active}, 64'd0);
      bus_if.tone_in = 1'b0;
      step(300);
      compare_notes("stuck_high");

      // Reset in the middle of a note loses it silently.
      for (int i = 0; i < 3; i++) play(100, 100);
      bus_if.tone_in = 1'b1;
      step(50);
      check("pre_rst_active", {63'd0, bus_if.tone_active}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, bus_if.note_valid}, 64'd0);
      check("mid_rst_hp", 64'(bus_if.note_halfperiod), 64'd0);
      check("mid_rst_cyc", 64'(bus_if.note_cycles), 64'd0);
      check("mid_rst_active", {63'd0, bus_if.tone_active}, 64'd0);
      m_cnt = 0;
      bus_if.tone_in = 1'b0;
      step(5);
      rst_n = 1'b1;
      step(20);
      play(100, 100); play(100, 100); play(100, 300);
      compare_notes("after_reset");

      // Short glitch inside a low phase.
      for (int i = 0; i < 3; i++) play(100, 100);
      play_glitch();
      play(100, 100);
      play(100, 300);
      compare_notes("glitch");

      // Randomized notes with jitter and random silences.
      for (int n = 0; n < 6; n++) begin
         base = int'($urandom_range(20, 150));
         k = int'($urandom_range(1, 4));
         for (int j = 0; j < k; j++) begin
            h = (j == 0) ? base : base + int'($urandom_range(0, 8)) - 4;
            l = int'($urandom_range(10, base));
            if (j == k - 1) begin
               r = int'($urandom_range(0, 2));
               if (r == 1) l = 2 * base + TOL;
               else if (r == 2) l = 2 * base + TOL + 1 + int'($urandom_range(0, 50));
            end
            play(h, l);
         end
      end
      play(int'($urandom_range(20, 150)), 700);
      compare_notes("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
